// File: rtl/l0_loader_pkg.sv
// Shared types for the L0 activation loader: FSM states and holding-buffer depth.
package l0_loader_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  localparam int HOLD_DEPTH = 2;
endpackage

// File: rtl/l0_loader_hold.sv
// 2-entry holding FIFO between SRAM return and L0; 1-cycle push-to-head latency.
// No internal backpressure: the caller reserves space before pushing; push and pop may coincide.
module l0_loader_hold
  import l0_loader_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_dat,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic [1:0]       count
);

  logic [width-1:0] mem [HOLD_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HOLD_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/l0_loader.sv
// Streams len consecutive SRAM vectors into L0; first l0_wr 3 cycles after start, then 1/cycle.
// Stalls SRAM reads when L0 drops l0_ready so buffered + in-flight vectors never exceed 2.
module l0_loader
  import l0_loader_pkg::*;
#(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11,
  parameter int len_w  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic [len_w-1:0]  len,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [addr_w-1:0] sram_addr,
  input  logic [row*bw-1:0] sram_q,
  output logic              l0_wr,
  output logic [row*bw-1:0] l0_in,
  input  logic              l0_ready,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  logic [addr_w-1:0] addr;
  logic [len_w-1:0]  len_q;
  logic [len_w-1:0]  issued;
  logic [len_w-1:0]  pushed;
  logic              in_flight;
  logic [1:0]        hold_cnt;
  logic [2:0]        slots_used;
  logic              rd_en;

  l0_loader_hold #(.width(row*bw)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .push     (in_flight),
    .push_dat (sram_q),
    .pop      (l0_wr),
    .head     (l0_in),
    .count    (hold_cnt)
  );

  assign l0_wr = (hold_cnt != 2'd0) & l0_ready;

  // Occupancy after this cycle's pop, so a steady stream keeps one read per cycle.
  assign slots_used = 3'(in_flight) + 3'(hold_cnt) - 3'(l0_wr);
  assign rd_en      = (state == FETCH) && (issued < len_q) && (slots_used < 3'(HOLD_DEPTH));

  assign sram_cen  = ~rd_en;
  assign sram_wen  = 1'b1;
  assign sram_addr = addr;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      len_q     <= '0;
      issued    <= '0;
      pushed    <= '0;
      in_flight <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_flight <= rd_en;
      if (state == IDLE && start) begin
        addr   <= base_addr;
        len_q  <= len;
        issued <= '0;
        pushed <= '0;
      end
      if (rd_en) begin
        addr   <= addr + addr_w'(1);
        issued <= issued + len_w'(1);
      end
      if (l0_wr) pushed <= pushed + len_w'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (len == '0) ? DONE : FETCH;
      FETCH: if (rd_en && (issued + len_w'(1) == len_q)) state_nxt = DRAIN;
      DRAIN: if (!in_flight && (pushed + len_w'(l0_wr) == len_q)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l0_loader.sv
// Scoreboard bench for l0_loader: stimulus queues expected reads/writes/done, a negedge monitor checks them.
module tb_l0_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] len;
  logic        sram_cen;
  logic        sram_wen;
  logic [10:0] sram_addr;
  logic [31:0] sram_q;
  logic        l0_wr;
  logic [31:0] l0_in;
  logic        l0_ready;
  logic        busy;
  logic        done;

  l0_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_q    (sram_q),
    .l0_wr     (l0_wr),
    .l0_in     (l0_in),
    .l0_ready  (l0_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [10:0] addr; int cyc; } exp_rd_t;
  typedef struct { logic [31:0] data; int cyc; } exp_wr_t;

  exp_rd_t exp_rd[$];
  exp_wr_t exp_wr[$];
  int      exp_done[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int t0      = 0;
  int rd_cnt  = 0;
  int wr_cnt  = 0;
  bit done_seen = 1'b0;

  function automatic logic [31:0] memf(input logic [10:0] a);
    return {a[7:0] ^ 8'h5A, 5'd0, a, a[7:0]};
  endfunction

  always @(posedge clk) cyc++;
  always @(posedge clk) sram_q <= (sram_cen == 1'b0) ? memf(sram_addr) : 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc - t0);
    end
  endtask

  task automatic unexp(input string nm);
    vectors++;
    errors++;
    $display("FAIL %s: got an event, want none (cycle %0d)", nm, cyc - t0);
  endtask

  always @(negedge clk) begin : monitor
    int      rel;
    exp_rd_t er;
    exp_wr_t ew;
    int      ed;
    rel = cyc - t0;
    if (sram_cen === 1'b0) begin
      rd_cnt++;
      chk("sram_wen", 32'(sram_wen), 32'd1);
      if (exp_rd.size() == 0) unexp("read");
      else begin
        er = exp_rd.pop_front();
        chk("read addr", 32'(sram_addr), 32'(er.addr));
        if (er.cyc >= 0) chk("read cycle", rel, er.cyc);
      end
    end
    if (l0_wr === 1'b1) begin
      wr_cnt++;
      chk("l0_wr with ready", 32'(l0_ready), 32'd1);
      if (exp_wr.size() == 0) unexp("l0_wr");
      else begin
        ew = exp_wr.pop_front();
        chk("l0_in data", l0_in, ew.data);
        if (ew.cyc >= 0) chk("l0_wr cycle", rel, ew.cyc);
      end
    end
    if (sram_cen === 1'b0) chk("buffered+in flight <= 2", 32'((rd_cnt - wr_cnt) <= 2), 32'd1);
    if (done === 1'b1) begin
      done_seen = 1'b1;
      if (exp_done.size() == 0) unexp("done");
      else begin
        ed = exp_done.pop_front();
        if (ed >= 0) chk("done cycle", rel, ed);
      end
    end
  end

  task automatic run(input logic [10:0] base, input logic [11:0] n, input int bp_lo, input int bp_hi,
                     input bit timed, input int intr, input logic [10:0] base2);
    logic [10:0] a;
    for (int i = 0; i < int'(n); i++) begin
      a = base + 11'(i);
      exp_rd.push_back('{a, timed ? 1 + i : -1});
      exp_wr.push_back('{memf(a), timed ? 3 + i : -1});
    end
    exp_done.push_back(timed ? ((n == 0) ? 1 : int'(n) + 3) : -1);
    rd_cnt = 0;
    wr_cnt = 0;
    done_seen = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    base_addr = base;
    len = n;
    l0_ready = 1'b1;
    @(negedge clk);
    chk("busy in start cycle", 32'(busy), 32'd0);
    for (int k = 1; k < 300; k++) begin
      @(posedge clk); #1;
      if (done_seen) break;
      start     = (k == intr);
      base_addr = start ? base2 : base;
      len       = start ? 12'd3 : n;
      l0_ready  = !(k >= bp_lo && k <= bp_hi);
      @(negedge clk);
      chk("busy during run", 32'(busy), 32'd1);
    end
    start = 1'b0;
    l0_ready = 1'b1;
    if (!done_seen) unexp("timeout waiting for done");
    chk("busy after done", 32'(busy), 32'd0);
    chk("reads outstanding", exp_rd.size(), 0);
    chk("writes outstanding", exp_wr.size(), 0);
    chk("done outstanding", exp_done.size(), 0);
    exp_rd.delete();
    exp_wr.delete();
    exp_done.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " sram_cen"}, 32'(sram_cen), 32'd1);
    chk({tag, " sram_wen"}, 32'(sram_wen), 32'd1);
    chk({tag, " sram_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, " l0_wr"}, 32'(l0_wr), 32'd0);
    chk({tag, " l0_in"}, l0_in, 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
  endtask

  task automatic run_reset(input logic [10:0] base);
    for (int i = 0; i < 4; i++) exp_rd.push_back('{base + 11'(i), 1 + i});
    for (int i = 0; i < 2; i++) exp_wr.push_back('{memf(base + 11'(i)), 3 + i});
    rd_cnt = 0;
    wr_cnt = 0;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    base_addr = base;
    len = 12'd8;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 4) reset = 1'b1;
      @(negedge clk);
      chk("busy before abort", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("post-abort");
    chk("abort reads outstanding", exp_rd.size(), 0);
    chk("abort writes outstanding", exp_wr.size(), 0);
    rd_cnt = 0;
    wr_cnt = 0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    l0_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run(11'h010, 12'd4,  -1, -2, 1'b1, -1, 11'h000);
    run(11'h040, 12'd16,  5,  9, 1'b0, -1, 11'h000);
    run(11'h123, 12'd0,  -1, -2, 1'b1, -1, 11'h000);
    run(11'h7FE, 12'd4,  -1, -2, 1'b1, -1, 11'h000);
    run(11'h100, 12'd6,  -1, -2, 1'b1,  3, 11'h200);
    run(11'h600, 12'd5,   2,  3, 1'b0, -1, 11'h000);
    run_reset(11'h500);
    run(11'h300, 12'd2,  -1, -2, 1'b1, -1, 11'h000);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
